// File: rtl/debounce_bank.sv
// Multi-channel debouncer: 3-flop synchroniser, 2^CNT_W stability window, clean level plus rise/fall pulses.
// Optional long-press detection is compiled in with `define DEBOUNCE_BANK_HOLD_EN.
module debounce_bank #(
    parameter int unsigned     N          = 4,
    parameter int unsigned     CNT_W      = 16,
    parameter logic [N-1:0]    RST_VAL    = '0,
    parameter int unsigned     HOLD_TICKS = 64,
    parameter int unsigned     HOLD_W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_signal,
    output logic [N-1:0] o_state,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall,
    output logic [N-1:0] o_hold
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic             r_s0;
        logic             r_s1;
        logic             r_s2;
        logic [CNT_W-1:0] r_cnt;
        logic             r_state;
        logic             r_rise;
        logic             r_fall;
        logic             w_mismatch;
        logic             w_tick;
        logic             w_state_nxt;

        assign w_mismatch  = r_s2 ^ r_s1;
        assign w_tick      = !w_mismatch && (r_cnt == '1);
        assign w_state_nxt = w_tick ? r_s2 : r_state;

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_s0    <= RST_VAL[g];
                r_s1    <= RST_VAL[g];
                r_s2    <= RST_VAL[g];
                r_cnt   <= '0;
                r_state <= RST_VAL[g];
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_s0    <= i_signal[g];
                r_s1    <= r_s0;
                r_s2    <= r_s1;
                r_cnt   <= w_mismatch ? '0 : r_cnt + CNT_W'(1);
                r_state <= w_state_nxt;
                r_rise  <= w_tick && r_s2 && !r_state;
                r_fall  <= w_tick && !r_s2 && r_state;
            end
        end

        assign o_state[g] = r_state;
        assign o_rise[g]  = r_rise;
        assign o_fall[g]  = r_fall;

`ifdef DEBOUNCE_BANK_HOLD_EN
        logic [HOLD_W-1:0] r_hold_cnt;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic              r_hold;
        logic              w_pressed;
        logic              w_pressed_nxt;

        assign w_pressed     = r_state ^ RST_VAL[g];
        assign w_pressed_nxt = w_state_nxt ^ RST_VAL[g];

        always_comb begin
            w_hold_nxt = r_hold_cnt;
            if (!w_pressed) begin
                w_hold_nxt = '0;
            end else if (w_tick && (r_hold_cnt != HOLD_W'(HOLD_TICKS))) begin
                w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            end
        end

        // Gating with the next pressed state drops o_hold on the same edge o_state returns to idle.
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_hold_cnt <= '0;
                r_hold     <= 1'b0;
            end else begin
                r_hold_cnt <= w_hold_nxt;
                r_hold     <= w_pressed_nxt && (w_hold_nxt == HOLD_W'(HOLD_TICKS));
            end
        end

        assign o_hold[g] = r_hold;
`else
        assign o_hold[g] = 1'b0;
`endif
    end

`ifndef DEBOUNCE_BANK_HOLD_EN
    logic w_unused_hold_cfg;
    assign w_unused_hold_cfg = ^{HOLD_TICKS, HOLD_W};
`endif

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for push-buttons, switches and other slow mechanical inputs. Each channel synchronises its asynchronous input, requires it to be stable for 2^CNT_W clock cycles, and then publishes a clean level together with single-cycle rise and fall pulses. It sits between the board I/O pins and the memory-mapped GPIO or input peripheral and replaces the single-channel debouncer.

## Interface
- N, default 4: number of independent channels, 1..32.
- CNT_W, default 16: stability counter width; the required stable time is 2^CNT_W cycles.
- RST_VAL, default {N{1'b0}}: per-channel idle level, and the reset value of the synchronisers and of o_state.
- HOLD_TICKS, default 64: number of stable ticks before o_hold asserts (1..2^HOLD_W−1). Used only when the hold feature is compiled in.
- HOLD_W, default 8: width of the hold counter.

Ports:
- i_clk, input, 1: system clock. All logic is on the rising edge.
- i_rst, input, 1: asynchronous, active-low reset.
- i_signal, input, N: raw asynchronous inputs.
- o_state, output, N: debounced level.
- o_rise, output, N: one-cycle pulse when o_state goes 0→1.
- o_fall, output, N: one-cycle pulse when o_state goes 1→0.
- o_hold, output, N: level, asserted while a channel has been held pressed for HOLD_TICKS ticks.

## Operation
Each channel is fully independent and has identical logic.
- **Synchroniser.** A 3-flop shift register: s0 ← i_signal[i], s1 ← s0, s2 ← s1.
- **Mismatch.** mismatch = (s2 ≠ s1).
- **Counter.** The CNT_W-bit counter clears to 0 on mismatch; otherwise it increments and wraps.
- **Tick.** tick = !mismatch && (counter == 2^CNT_W−1).
- **Update.** On tick, o_state ← s2. With no tick, o_state holds.
- **Edge pulses.** o_rise ← tick && s2 && !o_state. o_fall ← tick && !s2 && o_state. Both are registered, so they are high in the same cycle o_state first shows its new value.
- **Repeated ticks.** Ticks that do not change the value produce no pulse.
- **Pressed.** pressed = o_state ^ RST_VAL[i], so active-low buttons use RST_VAL = 1.
- **Glitches.** Any input toggle shorter than the window never reaches o_state. Every mismatch restarts the full window.

## Timing
- **Reset values.** Asserting i_rst (low) forces:
  - s0, s1, s2 and o_state to RST_VAL;
  - counters and hold counters to 0;
  - o_rise, o_fall and o_hold to 0.
- **No pulse out of reset.** If i_signal equals RST_VAL at reset release, no pulse is ever produced.
- **Reset mid-operation.** In-flight counts and pulses are lost immediately. No pulse is emitted on release.
- **Latency.** Number edges so that the new stable value is first captured by s0 at edge 0:
  - s2 takes the new value, and the counter clears, at edge 2;
  - o_state and its edge pulse update at edge 2^CNT_W+2;
  - o_rise and o_fall are exactly 1 cycle wide.
- **Boundary case.** A single-cycle mismatch arriving in the cycle where counter == 2^CNT_W−1 suppresses that tick, and the counter clears.
- **Tick rate.** While the input is stable, ticks recur every 2^CNT_W cycles.

## Configuration
The macro DEBOUNCE_BANK_HOLD_EN selects the hold feature.
- **Defined:** each channel has a HOLD_W-bit hold counter.
  - It clears while !pressed.
  - On each tick while pressed, it increments, saturating at HOLD_TICKS.
  - o_hold is registered and equals (hold counter == HOLD_TICKS).
  - The counter is 0 at the tick on which o_state becomes pressed, so o_hold rises HOLD_TICKS·2^CNT_W cycles after the press edge.
  - o_hold falls on the same edge that o_state returns to idle.
- **Not defined:** no hold counters are built and o_hold is tied to 0. The port list is identical in both builds.

## Test plan
All scenarios use N=2, CNT_W=4, RST_VAL=2'b10, HOLD_TICKS=3.
- **Reset.** Release reset with i_signal=2'b10 and hold for 100 cycles. Required: o_state=2'b10, with o_rise, o_fall and o_hold all 0 throughout.
- **Clean press and release on ch0.** Step i_signal[0] to 1, first sampled at edge 0. Required: o_state[0]=1 and o_rise[0]=1 exactly at edge 18, with o_rise[0] low at edge 19. Stepping back to 0 gives o_fall[0] pulsing 18 edges after sampling.
- **Glitch rejection.** Toggle i_signal[0] every 10 cycles for 200 cycles, then hold it at 0. Required: o_state[0] stays 0 and no pulses occur.
- **Active-low ch1.** Drive i_signal[1] from 1 to 0. Required: o_fall[1] pulses at edge 18 and ch0 is undisturbed.
- **Hold, with DEBOUNCE_BANK_HOLD_EN defined.** Press ch0 and keep it pressed. Required: o_hold[0] rises 48 cycles after o_rise[0] and clears on the o_fall[0] edge. With the macro undefined, o_hold stays 0.
- **Reset mid-window.** Assert i_rst 10 cycles after ch0 starts a press, then release. Required: o_state returns to 2'b10 asynchronously, and there is no pulse on release.
